wb_burst_master: RTL and testbench

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master.sv | 175 +++++++++++++++++
 tb/tb_wb_burst_master.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Purpose : turns a burst command (1..8 beats, read or write) into Wishbone
//           incrementing-burst cycles towards the SDRAM controller slave.
// Latency : read data one clock after each ack; done two clocks after the last ack.
// Backpressure: cmd_ready only in IDLE with sdr_init_done; write beats stall
//           (stb low, cyc held) while wr_valid is low; rd stream has none.
// Ports   : cmd_* command handshake, wr_* write-beat stream, rd_* read-beat
//           stream, done/err completion pulses, wb_* Wishbone master side.
module wb_burst_master #(
    parameter int AW  = 26,
    parameter int DW  = 32,
    parameter int TMO = 256
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            sdr_init_done,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [2:0]      cmd_len,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [DW-1:0]   wr_data,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            done,
    output logic            err,
    output logic            wb_cyc_i,
    output logic            wb_stb_i,
    output logic            wb_we_i,
    output logic [AW-1:0]   wb_addr_i,
    output logic [DW-1:0]   wb_dat_i,
    output logic [DW/8-1:0] wb_sel_i,
    output logic [2:0]      wb_cti_i,
    input  logic            wb_ack_o,
    input  logic [DW-1:0]   wb_dat_o
);

    typedef enum logic [1:0] {IDLE, LOAD, BEAT, FIN} state_t;

    localparam int          TW      = $clog2(TMO + 1);
    localparam logic [2:0]  CTI_INC = 3'b010;
    localparam logic [2:0]  CTI_END = 3'b111;
    localparam logic [AW-1:0] STEP  = AW'(DW / 8);

    state_t            state_q;
    logic              cyc_q, stb_q, we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     dat_q;
    logic [DW/8-1:0]   sel_q;
    logic [2:0]        cti_q;
    logic [2:0]        len_q;
    logic [2:0]        beat_q;
    logic [TW-1:0]     tmo_q;
    logic              rd_valid_q, done_q, err_q;
    logic [DW-1:0]     rd_data_q;

    logic              last_beat;
    logic [2:0]        beat_d;
    logic              take_next;

    assign last_beat = (beat_q == len_q);
    assign beat_d    = beat_q + 3'd1;
    // Next write beat is pulled in the ack cycle so stb stays high across beats.
    assign take_next = (state_q == BEAT) && wb_ack_o && we_q && !last_beat;

    assign cmd_ready = (state_q == IDLE) && sdr_init_done;
    assign wr_ready  = (state_q == LOAD) || take_next;

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            cti_q      <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        we_q   <= cmd_we;
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        sel_q  <= cmd_sel;
                        beat_q <= '0;
                        tmo_q  <= '0;
                        cti_q  <= (cmd_len == 3'd0) ? CTI_END : CTI_INC;
                        if (cmd_we) begin
                            state_q <= LOAD;
                        end else begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            state_q <= BEAT;
                        end
                    end
                end
                LOAD: begin
                    if (wr_valid) begin
                        dat_q   <= wr_data;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= BEAT;
                    end
                end
                BEAT: begin
                    if (wb_ack_o) begin
                        beat_q <= beat_d;
                        addr_q <= addr_q + STEP;
                        tmo_q  <= '0;
                        if (!we_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= wb_dat_o;
                        end
                        if (last_beat) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            state_q <= FIN;
                        end else begin
                            cti_q <= (beat_d == len_q) ? CTI_END : CTI_INC;
                            if (we_q) begin
                                if (wr_valid) begin
                                    dat_q <= wr_data;
                                end else begin
                                    // Write data not ready: pause the strobe but keep the cycle open.
                                    stb_q   <= 1'b0;
                                    state_q <= LOAD;
                                end
                            end
                        end
                    end else if (tmo_q == TW'(TMO - 1)) begin
                        // Slave never answered: abandon the rest of the burst.
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_cyc_i  = cyc_q;
    assign wb_stb_i  = stb_q;
    assign wb_we_i   = we_q;
    assign wb_addr_i = addr_q;
    assign wb_dat_i  = dat_q;
    assign wb_sel_i  = sel_q;
    assign wb_cti_i  = cti_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Purpose : directed self-checking bench for wb_burst_master.
// Latency : n/a (bench).
// Backpressure: slave ack either follows stb each cycle or is driven by hand.
module tb_wb_burst_master;

    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int TMO = 256;

    logic          sys_clk = 1'b0;
    logic          RESETN = 1'b0;
    logic          sdr_init_done = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [2:0]    cmd_len = '0;
    logic [3:0]    cmd_sel = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [31:0]   wr_data = '0;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          done, err;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW-1:0] wb_addr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [2:0]    wb_cti_i;
    logic          wb_ack_o;
    logic [31:0]   wb_dat_o;

    logic          ack_follow = 1'b0;
    logic          ack_man = 1'b0;
    logic          dat_follow = 1'b0;
    logic [31:0]   dat_man = '0;

    int checks = 0;
    int failures = 0;

    // Observations collected by run_burst
    logic [AW-1:0] obs_addr [8];
    logic [2:0]    obs_cti  [8];
    logic [31:0]   obs_dat  [8];
    logic [31:0]   obs_rd   [8];
    int obs_n, rdv_n, done_n, err_n, stall_n, stall_moved, attr_bad;
    logic [AW-1:0] stall_addr;

    always #5 sys_clk = ~sys_clk;

    assign wb_ack_o = ack_follow ? wb_stb_i : ack_man;
    assign wb_dat_o = dat_follow ? {16'hC0DE, wb_addr_i[15:0]} : dat_man;

    wb_burst_master #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .sys_clk(sys_clk), .RESETN(RESETN), .sdr_init_done(sdr_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_cti_i(wb_cti_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o)
    );

    // Present a command and wait (bounded) for it to be taken; returns just after the accepting edge.
    task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [2:0] l, output bit ok);
        ok = 1'b0;
        @(negedge sys_clk);
        cmd_we = we; cmd_addr = a; cmd_len = l; cmd_sel = 4'hF; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(posedge sys_clk);
            if (!ok) @(negedge sys_clk);
        end
        #1 cmd_valid = 1'b0;
    endtask

    // Run a burst already accepted, feeding write beats base+i and recording the bus.
    task automatic run_burst(input int budget, input logic exp_we, input int nbeats, input logic [31:0] base,
                             input int gap_after, input int gap_len);
        int  wi = 0;
        int  gap_left = 0;
        bit  hs;
        bit  fin = 1'b0;
        obs_n = 0; rdv_n = 0; done_n = 0; err_n = 0; stall_n = 0; stall_moved = 0; attr_bad = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge sys_clk);
            if (wb_cyc_i && wb_stb_i && wb_ack_o && obs_n < 8) begin
                obs_addr[obs_n] = wb_addr_i; obs_cti[obs_n] = wb_cti_i; obs_dat[obs_n] = wb_dat_i;
                if (wb_we_i !== exp_we || wb_sel_i !== 4'hF) attr_bad++;
                obs_n++;
            end
            if (wb_cyc_i && !wb_stb_i) begin
                if (stall_n == 0) stall_addr = wb_addr_i;
                else if (wb_addr_i !== stall_addr) stall_moved++;
                stall_n++;
            end
            if (rd_valid && rdv_n < 8) begin obs_rd[rdv_n] = rd_data; rdv_n++; end
            if (err) err_n++;
            if (done) begin done_n++; fin = 1'b1; end
            hs = wr_valid && wr_ready;
            @(posedge sys_clk);
            #1;
            if (hs) begin
                wi++;
                wr_data = base + 32'(wi);
                if (gap_after > 0 && wi == gap_after) gap_left = gap_len;
            end
            if (gap_left > 0) begin wr_valid = 1'b0; gap_left--; end
            else wr_valid = (wi < nbeats);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        RESETN = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i, rd_valid, done, err} !== 9'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i, rd_valid, done, err});
        end
        checks++;
        if (wb_addr_i !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", wb_addr_i); end
        checks++;
        if ({wb_dat_i, rd_data, wb_sel_i} !== 68'b0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", wb_dat_i, rd_data, wb_sel_i);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
        RESETN = 1'b1;
    endtask

    task automatic test_init_gating;
        int bad = 0;
        bit got = 1'b0;
        sdr_init_done = 1'b0;
        cmd_we = 1'b0; cmd_addr = 26'h10; cmd_len = 3'd0; cmd_sel = 4'hF; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            if (cmd_ready !== 1'b0 || wb_cyc_i !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL init_gate bad_cycles got=%0d exp=0", bad); end
        sdr_init_done = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL init_ready got=%b exp=1", cmd_ready); end
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i} !== 6'b110111 || wb_addr_i !== 26'h10) begin
            failures++; $display("FAIL init_accept got=%b addr=%h exp=110111 addr=10", {wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i}, wb_addr_i);
        end
        ack_man = 1'b1; dat_man = 32'h1111_2222;
        @(negedge sys_clk);
        ack_man = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1111_2222) begin
            failures++; $display("FAIL init_rd got=%b/%h exp=1/11112222", rd_valid, rd_data);
        end
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge sys_clk);
            if (done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL init_done got=0 exp=1"); end
    endtask

    task automatic test_write_burst;
        bit ok;
        ack_follow = 1'b1;
        wr_valid = 1'b1; wr_data = 32'hA0;
        send_cmd(1'b1, 26'h40, 3'd3, ok);
        run_burst(40, 1'b1, 4, 32'hA0, 0, 0);
        checks++;
        if (!ok || obs_n != 4 || done_n != 1 || err_n != 0) begin
            failures++; $display("FAIL wr_burst ok/beats/done/err got=%0d/%0d/%0d/%0d exp=1/4/1/0", ok, obs_n, done_n, err_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== 26'h40 + 26'(4 * i) || obs_dat[i] !== 32'hA0 + 32'(i) ||
                obs_cti[i] !== ((i == 3) ? 3'b111 : 3'b010)) begin
                failures++;
                $display("FAIL wr_beat%0d got addr=%h dat=%h cti=%b exp addr=%h dat=%h cti=%b", i, obs_addr[i], obs_dat[i],
                         obs_cti[i], 26'h40 + 26'(4 * i), 32'hA0 + 32'(i), (i == 3) ? 3'b111 : 3'b010);
            end
        end
        checks++;
        if (stall_n != 0 || attr_bad != 0) begin
            failures++; $display("FAIL wr_nostall stall/attr got=%0d/%0d exp=0/0", stall_n, attr_bad);
        end
        ack_follow = 1'b0;
    endtask

    task automatic test_write_gap;
        bit ok;
        ack_follow = 1'b1;
        wr_valid = 1'b1; wr_data = 32'hB0;
        send_cmd(1'b1, 26'h200, 3'd3, ok);
        // Dropping init mid-burst must not disturb it.
        sdr_init_done = 1'b0;
        run_burst(40, 1'b1, 4, 32'hB0, 2, 3);
        sdr_init_done = 1'b1;
        checks++;
        if (!ok || obs_n != 4 || done_n != 1) begin
            failures++; $display("FAIL gap_burst ok/beats/done got=%0d/%0d/%0d exp=1/4/1", ok, obs_n, done_n);
        end
        checks++;
        if (stall_n != 3 || stall_moved != 0 || stall_addr !== 26'h208) begin
            failures++; $display("FAIL gap_stall cycles=%0d moved=%0d addr=%h exp 3/0/208", stall_n, stall_moved, stall_addr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== 26'h200 + 26'(4 * i) || obs_dat[i] !== 32'hB0 + 32'(i)) begin
                failures++;
                $display("FAIL gap_beat%0d got addr=%h dat=%h exp addr=%h dat=%h", i, obs_addr[i], obs_dat[i],
                         26'h200 + 26'(4 * i), 32'hB0 + 32'(i));
            end
        end
        ack_follow = 1'b0;
    endtask

    task automatic test_read_single;
        bit ok;
        int bad = 0;
        send_cmd(1'b0, 26'h100, 3'd0, ok);
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            if (wb_stb_i !== 1'b1 || wb_cti_i !== 3'b111 || wb_addr_i !== 26'h100 || rd_valid !== 1'b0) bad++;
        end
        @(negedge sys_clk);
        checks++;
        if (!ok || bad != 0 || wb_stb_i !== 1'b1) begin
            failures++; $display("FAIL rd1_wait ok=%0d bad=%0d stb=%b exp 1/0/1", ok, bad, wb_stb_i);
        end
        ack_man = 1'b1; dat_man = 32'hDEAD_BEEF;
        @(negedge sys_clk);
        ack_man = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF || done !== 1'b0 || wb_cyc_i !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL rd1_data got rdv=%b data=%h done=%b cyc=%b rdy=%b exp 1/deadbeef/0/0/0",
                                 rd_valid, rd_data, done, wb_cyc_i, cmd_ready);
        end
        @(negedge sys_clk);
        checks++;
        if (done !== 1'b1 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL rd1_done got done=%b rdv=%b exp 1/0", done, rd_valid);
        end
        @(negedge sys_clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL rd1_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_timeout;
        bit ok;
        int err_k = -1;
        int err_cnt = 0;
        int rdv_cnt = 0;
        int stb_drop = 0;
        logic cyc_at_err = 1'b1;
        ack_follow = 1'b0; ack_man = 1'b0;
        send_cmd(1'b0, 26'h300, 3'd2, ok);
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk);
            if (err) begin
                err_cnt++;
                if (err_k < 0) begin err_k = k; cyc_at_err = wb_cyc_i; end
            end
            if (rd_valid) rdv_cnt++;
            if (err_k < 0 && k < 256 && wb_stb_i !== 1'b1) stb_drop++;
        end
        checks++;
        if (!ok || err_k != 256 || err_cnt != 1) begin
            failures++; $display("FAIL tmo_err ok=%0d at=%0d pulses=%0d exp 1/256/1", ok, err_k, err_cnt);
        end
        checks++;
        if (cyc_at_err !== 1'b0 || rdv_cnt != 0 || stb_drop != 0) begin
            failures++; $display("FAIL tmo_bus cyc=%b rdv=%0d stb_drop=%0d exp 0/0/0", cyc_at_err, rdv_cnt, stb_drop);
        end
        ack_follow = 1'b1; dat_follow = 1'b1;
        send_cmd(1'b0, 26'h310, 3'd0, ok);
        run_burst(20, 1'b0, 0, 32'h0, 0, 0);
        checks++;
        if (!ok || done_n != 1 || rdv_n != 1 || obs_rd[0] !== 32'hC0DE_0310) begin
            failures++; $display("FAIL tmo_next ok=%0d done=%0d rdv=%0d data=%h exp 1/1/1/c0de0310", ok, done_n, rdv_n, obs_rd[0]);
        end
        ack_follow = 1'b0; dat_follow = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        int acks = 0;
        int stray = 0;
        ack_follow = 1'b1; dat_follow = 1'b1;
        send_cmd(1'b0, 26'h400, 3'd7, ok);
        for (int c = 0; c < 20 && acks < 2; c++) begin
            @(negedge sys_clk);
            if (wb_stb_i && wb_ack_o) acks++;
        end
        @(posedge sys_clk);
        #2 RESETN = 1'b0;
        #1;
        checks++;
        if (!ok || acks != 2 || {wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i, rd_valid, done, err} !== 9'b0) begin
            failures++; $display("FAIL rst_mid_ctrl ok=%0d acks=%0d got=%b exp 1/2/0", ok, acks,
                                 {wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i, rd_valid, done, err});
        end
        checks++;
        if ({wb_addr_i, wb_dat_i, rd_data, wb_sel_i} !== 94'b0) begin
            failures++; $display("FAIL rst_mid_data got=%h/%h/%h/%h exp=0", wb_addr_i, wb_dat_i, rd_data, wb_sel_i);
        end
        repeat (2) begin
            @(negedge sys_clk);
            if (done || err) stray++;
        end
        RESETN = 1'b1;
        repeat (2) begin
            @(negedge sys_clk);
            if (done || err) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL rst_mid_stray got=%0d exp=0", stray); end
        // Recovery burst also exercises address wrap at the top of the space.
        send_cmd(1'b0, 26'h3FF_FFFC, 3'd1, ok);
        run_burst(20, 1'b0, 0, 32'h0, 0, 0);
        checks++;
        if (!ok || done_n != 1 || rdv_n != 2 || obs_rd[0] !== 32'hC0DE_FFFC || obs_rd[1] !== 32'hC0DE_0000) begin
            failures++; $display("FAIL rst_recover ok=%0d done=%0d rdv=%0d d0=%h d1=%h exp 1/1/2/c0defffc/c0de0000",
                                 ok, done_n, rdv_n, obs_rd[0], obs_rd[1]);
        end
        checks++;
        if (obs_n != 2 || obs_addr[1] !== 26'h0 || obs_cti[0] !== 3'b010 || obs_cti[1] !== 3'b111) begin
            failures++; $display("FAIL rst_wrap beats=%0d a1=%h cti=%b/%b exp 2/0/010/111", obs_n, obs_addr[1], obs_cti[0], obs_cti[1]);
        end
        ack_follow = 1'b0; dat_follow = 1'b0;
    endtask

    initial begin
        test_reset;
        test_init_gating;
        test_write_burst;
        test_write_gap;
        test_read_single;
        test_timeout;
        test_reset_mid_burst;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
